// File: rtl/cassette_pkg.sv
// Shared definitions for the cassette transport controller and player.
// Holds the transport state encoding, the default pulse/filter timings and
// the player's bit-cell timing constants so both sides agree on them.
package cassette_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    PLAYING = 2'd3
  } tstate_t;

  localparam int PULSE_CYCLES_DEF = 4;
  localparam int MOTOR_FILTER_DEF = 1024;

  // Cassette player bit-cell timing in clk cycles.
  localparam int BIT0_CYCLES = 1200;
  localparam int BIT1_CYCLES = 2400;

endpackage

// File: rtl/cassette_transport_ctrl_if.sv
// Tape image RAM bus.
//  master : controller side, drives address / write enable / write data
//  slave  : RAM side, returns read data one clk after the address
//  ram_addr  ADDR_W  RAM address
//  ram_we    1       write enable
//  ram_wdata 8       write data
//  ram_rdata 8       read data (synchronous, 1-cycle latency)
interface cassette_transport_ctrl_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/cassette_transport_ctrl_filter.sv
// signal_filter: two-flop synchroniser followed by a stability counter.
//  clk, rst_n : clock, async active-low reset
//  din        : raw asynchronous input
//  dout       : filtered level; follows din once the synchronised value
//               has differed from dout for FILTER consecutive cycles
module signal_filter #(
  parameter int FILTER = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // Any return to the current output level restarts the stability count.
      if (sync_p1 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        dout <= sync_p1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cassette_transport_ctrl.sv
// cassette_transport_ctrl: transport controller and tape-RAM arbiter.
// The host download port owns the tape RAM while an image loads, the
// cassette player owns it otherwise. Tracks the highest written address,
// turns OSD button edges into fixed-width play/rewind pulses and gates the
// filtered CPU motor line.
//  clk, rst_n      : clock, async active-low reset
//  dl_active/wr/addr/data : host download bus
//  btn_play, btn_rewind   : OSD button levels
//  motor_i         : raw CPU motor line
//  cass_addr, cass_playing: player read address / busy flag
//  cass_data       : tape byte to player
//  tape_end        : highest address written by the last download
//  play_o, rewind_o: PULSE_CYCLES-wide pulses to the player
//  motor_o         : filtered motor, only while READY or PLAYING
//  ram             : tape RAM bus (master side)
//  tape_loaded     : a non-empty image is present
module cassette_transport_ctrl
  import cassette_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int MOTOR_FILTER = MOTOR_FILTER_DEF,
  parameter int ADDR_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dl_active,
  input  logic                  dl_wr,
  input  logic [ADDR_W-1:0]     dl_addr,
  input  logic [7:0]            dl_data,
  input  logic                  btn_play,
  input  logic                  btn_rewind,
  input  logic                  motor_i,
  input  logic [ADDR_W-1:0]     cass_addr,
  input  logic                  cass_playing,
  output logic [7:0]            cass_data,
  output logic [ADDR_W-1:0]     tape_end,
  output logic                  play_o,
  output logic                  rewind_o,
  output logic                  motor_o,
  cassette_transport_ctrl_if.master ram,
  output logic                  tape_loaded
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  tstate_t       state, state_nx;
  logic          dl_prev, play_prev, rew_prev, cass_prev, filt_prev;
  logic          motor_filt;
  logic          wrote;
  logic [PW-1:0] pulse_cnt;
  logic          pulse_rew;
  logic          play_req, rew_req;
  logic          dl_rise, play_rise, rew_rise, cass_fall, motor_rise, motor_fall;
  logic          host_sel;

  signal_filter #(.FILTER(MOTOR_FILTER)) motor_flt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (motor_i),
    .dout (motor_filt)
  );

  assign dl_rise    = dl_active & ~dl_prev;
  assign play_rise  = btn_play & ~play_prev;
  assign rew_rise   = btn_rewind & ~rew_prev;
  assign cass_fall  = ~cass_playing & cass_prev;
  assign motor_rise = motor_filt & ~filt_prev;
  assign motor_fall = ~motor_filt & filt_prev;

  // Host owns the RAM only once the FSM has registered the load, so a reset
  // or an idle controller always hands the bus back to the player.
  assign host_sel      = (state == LOADING) & dl_active;
  assign ram.ram_addr  = host_sel ? dl_addr : cass_addr;
  assign ram.ram_we    = host_sel & dl_wr;
  assign ram.ram_wdata = dl_data;
  assign cass_data     = ram.ram_rdata;

  assign play_o   = (pulse_cnt != '0) & ~pulse_rew;
  assign rewind_o = (pulse_cnt != '0) & pulse_rew;
  assign motor_o  = motor_filt & ((state == READY) | (state == PLAYING));

  always_comb begin
    state_nx = state;
    play_req = 1'b0;
    rew_req  = 1'b0;
    if (dl_rise) begin
      state_nx = LOADING;
      rew_req  = (state == PLAYING);
    end else begin
      case (state)
        LOADING: if (!dl_active) state_nx = wrote ? READY : EMPTY;
        READY: begin
          if (play_rise) begin
            state_nx = PLAYING;
            play_req = 1'b1;
          end else if (motor_rise) begin
            state_nx = PLAYING;
          end
        end
        PLAYING: begin
          if (rew_rise) begin
            state_nx = READY;
            rew_req  = 1'b1;
          end else if (cass_fall || motor_fall) begin
            state_nx = READY;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      dl_prev     <= 1'b0;
      play_prev   <= 1'b0;
      rew_prev    <= 1'b0;
      cass_prev   <= 1'b0;
      filt_prev   <= 1'b0;
      wrote       <= 1'b0;
      tape_end    <= '0;
      tape_loaded <= 1'b0;
      pulse_cnt   <= '0;
      pulse_rew   <= 1'b0;
    end else begin
      state     <= state_nx;
      dl_prev   <= dl_active;
      play_prev <= btn_play;
      rew_prev  <= btn_rewind;
      cass_prev <= cass_playing;
      filt_prev <= motor_filt;

      if (dl_rise) begin
        wrote       <= 1'b0;
        tape_end    <= '0;
        tape_loaded <= 1'b0;
      end else if (host_sel && dl_wr) begin
        wrote <= 1'b1;
        if (dl_addr > tape_end) tape_end <= dl_addr;
      end else if (state == LOADING && !dl_active) begin
        tape_loaded <= wrote;
      end

      // A request arriving while a pulse is running is dropped; rewind has
      // priority because the FSM never raises both in one cycle from PLAYING.
      if (pulse_cnt == '0 && (rew_req || play_req)) begin
        pulse_cnt <= PW'(PULSE_CYCLES);
        pulse_rew <= rew_req;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cassette_transport_ctrl.sv
module tb_cassette_transport_ctrl import cassette_pkg::*; ();
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_active, dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        btn_play, btn_rewind, motor_i;
  logic [15:0] cass_addr;
  logic        cass_playing;
  logic [7:0]  cass_data;
  logic [15:0] tape_end;
  logic        play_o, rewind_o, motor_o, tape_loaded;

  int checks = 0;
  int errors = 0;

  cassette_transport_ctrl_if #(.ADDR_W(16)) ram ();

  cassette_transport_ctrl #(.PULSE_CYCLES(4), .MOTOR_FILTER(1024), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .btn_play(btn_play), .btn_rewind(btn_rewind), .motor_i(motor_i),
    .cass_addr(cass_addr), .cass_playing(cass_playing), .cass_data(cass_data),
    .tape_end(tape_end), .play_o(play_o), .rewind_o(rewind_o), .motor_o(motor_o),
    .ram(ram.master), .tape_loaded(tape_loaded)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_wdata;
    ram.ram_rdata <= mem[ram.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, pc, rc;
    logic bad;
    rst_n = 1'b0; dl_active = 0; dl_wr = 0; dl_addr = 0; dl_data = 0;
    btn_play = 0; btn_rewind = 0; motor_i = 0; cass_addr = 0; cass_playing = 0;
    repeat (3) tick();
    check("rst_state", 32'(dut.state), 32'(EMPTY));
    check("rst_outs", {26'd0, play_o, rewind_o, motor_o, ram.ram_we, tape_loaded, 1'b0}, 32'd0);
    check("rst_tape_end", 32'(tape_end), 32'd0);
    check("rst_ram_addr", 32'(ram.ram_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty download, stray write strobe, buttons in EMPTY
    dl_wr = 1; dl_addr = 16'h0040;
    #1 check("we_ignored_idle", 32'(ram.ram_we), 32'd0);
    dl_wr = 0; btn_play = 1;
    tick();
    check("btn_ignored_empty", {30'd0, play_o, dl_active}, 32'd0);
    btn_play = 0;
    dl_active = 1; tick(); tick();
    check("empty_loading", 32'(dut.state), 32'(LOADING));
    dl_active = 0; tick();
    check("empty_state", 32'(dut.state), 32'(EMPTY));
    check("empty_loaded", 32'(tape_loaded), 32'd0);
    check("empty_tape_end", 32'(tape_end), 32'd0);

    // Full download 0..0x1FF
    dl_active = 1; tick();
    for (int a = 0; a < 512; a++) begin
      dl_wr = 1; dl_addr = 16'(a); dl_data = 8'(a) ^ 8'h5A;
      if (a == 5) begin
        #1 check("load_pass_addr", 32'(ram.ram_addr), 32'h5);
        check("load_pass_we", 32'(ram.ram_we), 32'd1);
      end
      tick();
    end
    dl_wr = 0; dl_active = 0; tick();
    check("load_tape_end", 32'(tape_end), 32'h01FF);
    check("load_loaded", 32'(tape_loaded), 32'd1);
    check("load_state", 32'(dut.state), 32'(READY));

    // Play pulse and player reads
    btn_play = 1; tick();
    check("play_state", 32'(dut.state), 32'(PLAYING));
    pc = 0; rc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("play_first", 32'(play_o), 32'd1);
      pc += int'(play_o); rc += int'(rewind_o);
      tick();
    end
    check("play_width", 32'(pc), 32'd4);
    check("play_no_rew", 32'(rc), 32'd0);
    btn_play = 0; cass_playing = 1; cass_addr = 16'h0010;
    #1 check("cass_ram_addr", 32'(ram.ram_addr), 32'h0010);
    check("cass_ram_we", 32'(ram.ram_we), 32'd0);
    tick();
    check("cass_data", 32'(cass_data), 32'h4A);

    // Download while playing: rewind pulse and new tape_end
    dl_active = 1; tick();
    check("reload_state", 32'(dut.state), 32'(LOADING));
    cass_playing = 0;
    rc = int'(rewind_o);
    dl_wr = 1; dl_addr = 16'h0100; dl_data = 8'hA1;
    #1 check("reload_we", 32'(ram.ram_we), 32'd1);
    tick(); rc += int'(rewind_o);
    dl_addr = 16'h0300; dl_data = 8'hC3; tick(); rc += int'(rewind_o);
    dl_addr = 16'h0200; dl_data = 8'hB2; tick(); rc += int'(rewind_o);
    dl_wr = 0;
    #1 check("reload_we_off", 32'(ram.ram_we), 32'd0);
    tick(); rc += int'(rewind_o);
    check("reload_rew_width", 32'(rc), 32'd4);
    dl_active = 0; tick();
    check("reload_tape_end", 32'(tape_end), 32'h0300);
    check("reload_state2", 32'(dut.state), 32'(READY));
    cass_addr = 16'h0300; tick();
    check("reload_readback", 32'(cass_data), 32'hC3);
    cass_addr = 16'h0000;

    // Motor filter
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      motor_i = ~motor_i;
      repeat (500) begin tick(); if (motor_o !== 1'b0) bad = 1'b1; end
    end
    check("motor_toggle_blocked", 32'(bad), 32'd0);
    motor_i = 1; n = 0;
    while (motor_o !== 1'b1 && n < 2000) begin tick(); n++; end
    check("motor_on_delay", 32'(n), 32'd1026);
    tick();
    check("motor_state_play", 32'(dut.state), 32'(PLAYING));
    check("motor_no_pulse", 32'(play_o), 32'd0);
    motor_i = 0; n = 0;
    while (motor_o !== 1'b0 && n < 2000) begin tick(); n++; end
    check("motor_off_delay", 32'(n), 32'd1026);
    tick();
    check("motor_state_ready", 32'(dut.state), 32'(READY));

    // Simultaneous play/rewind edges in PLAYING
    btn_play = 1; tick();
    cass_playing = 1;
    repeat (5) tick();
    btn_play = 0; tick();
    check("both_pre_state", 32'(dut.state), 32'(PLAYING));
    btn_play = 1; btn_rewind = 1; tick();
    check("both_state", 32'(dut.state), 32'(READY));
    pc = 0; rc = 0;
    for (int i = 0; i < 6; i++) begin
      pc += int'(play_o); rc += int'(rewind_o);
      tick();
    end
    check("both_rew_width", 32'(rc), 32'd4);
    check("both_no_play", 32'(pc), 32'd0);

    // Reset in the middle of a load started from PLAYING
    btn_play = 0; btn_rewind = 0; tick();
    btn_play = 1; tick();
    repeat (5) tick();
    btn_play = 0;
    dl_active = 1; tick();
    dl_wr = 1; dl_addr = 16'h0050; dl_data = 8'h11; tick();
    check("mid_tape_end", 32'(tape_end), 32'h0050);
    check("mid_rewind", 32'(rewind_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dut.state), 32'(EMPTY));
    check("arst_outs", {26'd0, play_o, rewind_o, motor_o, ram.ram_we, tape_loaded, 1'b0}, 32'd0);
    check("arst_tape_end", 32'(tape_end), 32'd0);
    check("arst_ram_addr", 32'(ram.ram_addr), 32'd0);
    dl_active = 0; dl_wr = 0; cass_playing = 0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_state", 32'(dut.state), 32'(EMPTY));
    check("post_rst_loaded", 32'(tape_loaded), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
